// File: rtl/cpu_pkg.sv
// Shared CPU constants: divider width, divider state encoding and the
// quotient value reported on a divide by zero.
package cpu_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;
  localparam logic [1:0] DIV_DONE = 2'd3;

  localparam logic [DIV_WIDTH-1:0] DIV_DBZ_QUO = 32'hFFFFFFFF;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes, MSB first.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_quo,
  input  logic [W-1:0] i_dvs,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_quo
);

  logic [W:0] w_shifted;
  logic       w_ge;

  // The shifted partial remainder can exceed W bits before the compare.
  assign w_shifted = {i_rem, i_quo[W-1]};
  assign w_ge      = (w_shifted >= {1'b0, i_dvs});
  assign o_rem     = w_ge ? (w_shifted[W-1:0] - i_dvs) : w_shifted[W-1:0];
  assign o_quo     = {i_quo[W-2:0], w_ge};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed truncating divider feeding the Z register pair
// (quotient -> LO, remainder -> HI); Busy stalls the control unit in div3.
//
// state     | meaning
// DIV_IDLE  | waiting for Start, outputs hold last result
// DIV_CALC  | one restoring step per cycle, WIDTH steps
// DIV_FIX   | apply signs (or divide-by-zero values), load outputs
// DIV_DONE  | Done pulse, back to IDLE on next edge
import cpu_pkg::*;

module seq_divider #(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dbz_pend;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // Magnitudes are unsigned WIDTH bits, so |-2^(WIDTH-1)| is exact.
  assign w_dvd_abs = i_dividend[WIDTH-1] ? (~i_dividend + 1'b1) : i_dividend;
  assign w_dvs_abs = i_divisor[WIDTH-1]  ? (~i_divisor + 1'b1)  : i_divisor;

  div_step #(.W(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_rem_next),
    .o_quo (w_quo_next)
  );

  // On divide by zero the dividend magnitude is still in r_quo; re-signing it
  // reproduces the original dividend for the remainder.
  assign w_rem_mag = r_dbz_pend ? r_quo : r_rem;
  assign w_quo_fix = r_qneg ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_fix = r_rneg ? (~w_rem_mag + 1'b1) : w_rem_mag;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state       <= DIV_IDLE;
      r_cnt         <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_dvs         <= '0;
      r_qneg        <= 1'b0;
      r_rneg        <= 1'b0;
      r_dbz_pend    <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (i_start) begin
            r_rem         <= '0;
            r_quo         <= w_dvd_abs;
            r_dvs         <= w_dvs_abs;
            r_qneg        <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
            r_rneg        <= i_dividend[WIDTH-1];
            r_cnt         <= '0;
            r_div_by_zero <= 1'b0;
            r_dbz_pend    <= (i_divisor == '0);
            r_state       <= (i_divisor == '0) ? DIV_FIX : DIV_CALC;
          end
        end
        DIV_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= DIV_FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DIV_FIX: begin
          r_quotient    <= r_dbz_pend ? WIDTH'(DIV_DBZ_QUO) : w_quo_fix;
          r_remainder   <= w_rem_fix;
          r_div_by_zero <= r_dbz_pend;
          r_state       <= DIV_DONE;
        end
        DIV_DONE: r_state <= DIV_IDLE;
        default:  r_state <= DIV_IDLE;
      endcase
    end
  end

  assign o_busy        = (r_state != DIV_IDLE);
  assign o_done        = (r_state == DIV_DONE);
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Directed vector bench for seq_divider: table of divisions plus
// hand-written sequences for ignored Start and mid-operation reset.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        dbz;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  seq_divider dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_start       (start),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_busy        (busy),
    .o_done        (done),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Presents operands for one edge; returns just after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // k counts edges since and including the accepting edge.
  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (!done && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!done) begin
      failures++;
      checks++;
      $display("FAIL done_timeout actual=%0d edges required=done", k);
    end
  endtask

  initial begin
    int          k;
    logic [31:0] prev_q;

    vecs[0]  = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 34};
    vecs[1]  = '{32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, 34};
    vecs[2]  = '{32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0, 34};
    vecs[3]  = '{32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1, 2};
    vecs[4]  = '{32'd9,         32'd3,         32'd3,         32'd0,         1'b0, 34};
    vecs[5]  = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, 34};
    vecs[6]  = '{32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  1'b0, 34};
    vecs[7]  = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0, 34};
    vecs[8]  = '{32'h7FFFFFFF,  32'd1,         32'h7FFFFFFF,  32'd0,         1'b0, 34};
    vecs[9]  = '{32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB,  1'b1, 2};
    vecs[10] = '{32'h80000000,  32'd2,         32'hC0000000,  32'd0,         1'b0, 34};
    vecs[11] = '{32'd7,         32'd100,       32'd0,         32'd7,         1'b0, 34};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    prev_q = 32'd0;
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      chk($sformatf("v%0d_qhold", i), quotient, prev_q);
      wait_done(1, k);
      chk($sformatf("v%0d_latency", i), 32'(k), 32'(vecs[i].lat));
      chk($sformatf("v%0d_q", i), quotient, vecs[i].q);
      chk($sformatf("v%0d_r", i), remainder, vecs[i].r);
      chk($sformatf("v%0d_dbz", i), 32'(dbz), 32'(vecs[i].z));
      chk($sformatf("v%0d_busy_done", i), 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("v%0d_q_held", i), quotient, vecs[i].q);
      chk($sformatf("v%0d_dbz_held", i), 32'(dbz), 32'(vecs[i].z));
      prev_q = vecs[i].q;
    end

    // Second Start during the operation must be ignored.
    issue(32'd100, 32'd7);
    repeat (8) @(posedge clk);
    #1;
    issue(32'd50, 32'd5);
    chk("ign_busy", 32'(busy), 32'd1);
    wait_done(10, k);
    chk("ign_latency", 32'(k), 32'd34);
    chk("ign_q", quotient, 32'd14);
    chk("ign_r", remainder, 32'd2);
    @(posedge clk);
    #1;
    chk("ign_idle", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("ign_no_restart", 32'(busy), 32'd0);

    // Reset in the middle of a division discards it and clears outputs.
    issue(32'd100, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_q", quotient, 32'd0);
    chk("mrst_r", remainder, 32'd0);
    chk("mrst_dbz", 32'(dbz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'd20, 32'd6);
    wait_done(1, k);
    chk("mrst_latency", 32'(k), 32'd34);
    chk("mrst_q2", quotient, 32'd3);
    chk("mrst_r2", remainder, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
